ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have clock and reset decided as: one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  hold the EX/MEM register contents.
REQ-005 flush  in  1  load a bubble into the EX/MEM register.
REQ-006 rs_val, rt_val  in  32 each  ID/EX register-file operands.
REQ-007 imm  in  32  sign-extended immediate.
REQ-008 alu_src  in  1  selects the B operand: 1 = imm, 0 = forwarded rt.
REQ-009 alu_op  in  4  operation code.
REQ-010 f_rs, f_rt  in  2 each  forward selects from the forwarding unit:
- 00 = register file.
- 01 = EX/MEM result.
- 10 = wb_data.
- 11 = treated as 00.
REQ-011 wb_data  in  32  MEM/WB write-back value.
REQ-012 id_wn  in  5  destination register number.
REQ-013 id_WB, id_M  in  2 each  write-back and memory control bits.
REQ-014 ex_result  out  32  registered ALU result; also the 01 forward source.
REQ-015 ex_store  out  32  registered forwarded rt value.
REQ-016 ex_wn  out  5  registered destination; drives the forwarding unit's wn1.
REQ-017 ex_WB, ex_M  out  2 each  registered control; ex_WB drives the forwarding unit's WB1.
REQ-018 ex_zero, ex_ovf  out  1 each  registered zero flag and signed-overflow flag.

Function
REQ-019 Operand A SHALL be selected per f_rs, with the 01 source being the current ex_result register.
REQ-020 Forwarded rt SHALL be selected per f_rt; operand B = alu_src ? imm : forwarded rt.
REQ-021 alu_op encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT (signed; result 1 or 0).
- 7 SLL, 8 SRL, 9 SRA; shift amount = B[4:0], operand A shifted.
- A LUI: {B[15:0],16'h0}.
- Any other code: result 0.
REQ-022 ADD/SUB SHALL wrap modulo 2^32.
REQ-023 ovf SHALL be 1 only for signed overflow on ADD/SUB, else 0.
REQ-024 zero SHALL be 1 when the 32-bit result equals 0.
REQ-025 Latency SHALL be one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-026 When stall=1 and flush=0, all output registers SHALL hold their values.
REQ-027 When flush=1, the register SHALL load a bubble (all outputs 0) regardless of stall; flush has priority.
REQ-028 When stall=0 and flush=0, the register SHALL load the new result, forwarded rt, id_wn, id_WB, id_M and the flags.
REQ-029 Back-to-back dependent operations SHALL be correct: a 01 forward in cycle N+1 uses the result registered at edge N.

Reset
REQ-030 Reset assertion SHALL immediately (asynchronously) clear every output to 0, including mid-stall.
REQ-031 After reset deassertion, the first rising edge with stall=0 SHALL load normally.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the alu_op constants and the forward-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB).
REQ-033 A combinational sub-module alu (A, B, op -> result, zero, ovf) SHALL hold the arithmetic; ex_stage holds the muxes and the EX/MEM register.

Verification
REQ-034 ADD overflow: f=00, rs_val=32'h7FFFFFFF, rt_val=1, ADD -> ex_result=32'h80000000, ex_ovf=1, ex_zero=0.
REQ-035 EX/MEM forward: cycle 1 ADD 5+3 (ex_result=8); cycle 2 f_rs=01, rt_val=8, SUB -> ex_result=0, ex_zero=1.
REQ-036 MEM/WB forward on rt: f_rt=10, wb_data=32'hA5A5A5A5, alu_src=0, XOR with rs_val=32'hFFFFFFFF -> ex_result=32'h5A5A5A5A, ex_store=32'hA5A5A5A5.
REQ-037 Stall then flush: load ADD 1+1 (ex_result=2); stall=1 with new inputs -> ex_result stays 2; stall=1 and flush=1 -> all outputs 0.
REQ-038 Async reset: with ex_WB=2'b10, drop rst mid-cycle -> all outputs 0 before the next edge.
REQ-039 Shifts and SLT: SRA 32'h80000000 by 4 -> 32'hF8000000; SLT -1 vs 1 -> 1; alu_op=4'hF -> ex_result=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline encodings for the execute stage
// Purpose: ALU operation codes and forward-select encodings used by ex_stage and alu.
// Ports: none (package).
package pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;
  localparam logic [3:0] ALU_LUI = 4'hA;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU for the execute stage
// Purpose: computes result, zero flag and signed-overflow flag from two operands.
// Ports:
//   a, b    in  32  operands
//   op      in  4   operation code (pipe_pkg ALU_*)
//   result  out 32  operation result (0 for undefined codes)
//   zero    out 1   result equals 0
//   ovf     out 1   signed overflow, ADD/SUB only
module alu
  import pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = 32'h0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        // operands share a sign but the result does not
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result = diff;
        // operands differ in sign and the result took the sign of b
        ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {31'h0, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $signed(a) >>> b[4:0];
      ALU_LUI: result = {b[15:0], 16'h0};
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding muxes, ALU and EX/MEM register
// Purpose: selects forwarded operands, runs the ALU and registers results into EX/MEM.
// Ports:
//   clk, rst           in   clock, asynchronous active-low reset
//   stall, flush       in   hold / bubble the EX/MEM register (flush wins)
//   rs_val, rt_val     in   32  register-file operands
//   imm                in   32  sign-extended immediate
//   alu_src            in   1   B operand: 1 = imm, 0 = forwarded rt
//   alu_op             in   4   operation code
//   f_rs, f_rt         in   2   forward selects (00 rf, 01 EX/MEM, 10 wb_data, 11 rf)
//   wb_data            in   32  MEM/WB write-back value
//   id_wn, id_WB, id_M in   destination register and control bits
//   ex_result, ex_store, ex_wn, ex_WB, ex_M, ex_zero, ex_ovf  out  EX/MEM register
module ex_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic [3:0]  alu_op,
  input  logic [1:0]  f_rs,
  input  logic [1:0]  f_rt,
  input  logic [31:0] wb_data,
  input  logic [4:0]  id_wn,
  input  logic [1:0]  id_WB,
  input  logic [1:0]  id_M,
  output logic [31:0] ex_result,
  output logic [31:0] ex_store,
  output logic [4:0]  ex_wn,
  output logic [1:0]  ex_WB,
  output logic [1:0]  ex_M,
  output logic        ex_zero,
  output logic        ex_ovf
);

  logic [31:0] op_a;
  logic [31:0] fwd_rt;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ovf;

  // The EX/MEM source is this stage's own registered result, which is what
  // makes back-to-back dependent operations work. Select 11 falls back to rf.
  always_comb begin
    op_a = rs_val;
    case (f_rs)
      FWD_EXMEM: op_a = ex_result;
      FWD_MEMWB: op_a = wb_data;
      default:   op_a = rs_val;
    endcase
  end

  always_comb begin
    fwd_rt = rt_val;
    case (f_rt)
      FWD_EXMEM: fwd_rt = ex_result;
      FWD_MEMWB: fwd_rt = wb_data;
      default:   fwd_rt = rt_val;
    endcase
  end

  assign op_b = alu_src ? imm : fwd_rt;

  alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_result <= 32'h0;
      ex_store  <= 32'h0;
      ex_wn     <= 5'h0;
      ex_WB     <= 2'h0;
      ex_M      <= 2'h0;
      ex_zero   <= 1'b0;
      ex_ovf    <= 1'b0;
    end else if (flush) begin
      ex_result <= 32'h0;
      ex_store  <= 32'h0;
      ex_wn     <= 5'h0;
      ex_WB     <= 2'h0;
      ex_M      <= 2'h0;
      ex_zero   <= 1'b0;
      ex_ovf    <= 1'b0;
    end else if (!stall) begin
      ex_result <= alu_result;
      ex_store  <= fwd_rt;
      ex_wn     <= id_wn;
      ex_WB     <= id_WB;
      ex_M      <= id_M;
      ex_zero   <= alu_zero;
      ex_ovf    <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [31:0] rs_val, rt_val, imm, wb_data;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [1:0]  f_rs, f_rt;
  logic [4:0]  id_wn;
  logic [1:0]  id_WB, id_M;
  logic [31:0] ex_result, ex_store;
  logic [4:0]  ex_wn;
  logic [1:0]  ex_WB, ex_M;
  logic        ex_zero, ex_ovf;

  int total = 0;
  int bad   = 0;

  // expected EX/MEM contents
  logic [31:0] m_result, m_store;
  logic [4:0]  m_wn;
  logic [1:0]  m_WB, m_M;
  logic        m_zero, m_ovf;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .f_rs(f_rs), .f_rt(f_rt), .wb_data(wb_data),
    .id_wn(id_wn), .id_WB(id_WB), .id_M(id_M),
    .ex_result(ex_result), .ex_store(ex_store), .ex_wn(ex_wn),
    .ex_WB(ex_WB), .ex_M(ex_M), .ex_zero(ex_zero), .ex_ovf(ex_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rf,
                                       input logic [31:0] exr, input logic [31:0] wb);
    if (f == 2'd1) return exr;
    if (f == 2'd2) return wb;
    return rf;
  endfunction

  // arithmetic reference: overflow judged on the exact mathematical sum
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic v);
    longint sa, sb, exact;
    logic [63:0] ext;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0;
    v = 1'b0;
    case (op)
      4'd0: begin exact = sa + sb; r = exact[31:0];
                  v = (exact > 64'sd2147483647) || (exact < -64'sd2147483648); end
      4'd1: begin exact = sa - sb; r = exact[31:0];
                  v = (exact > 64'sd2147483647) || (exact < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: begin ext = {{32{a[31]}}, a} >> b[4:0]; r = ext[31:0]; end
      4'd10: r = b * 32'd65536;
      default: r = 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] a, rtf, r;
    logic v;
    if (!rst) begin
      m_result = 0; m_store = 0; m_wn = 0; m_WB = 0; m_M = 0; m_zero = 0; m_ovf = 0;
    end else if (flush) begin
      m_result = 0; m_store = 0; m_wn = 0; m_WB = 0; m_M = 0; m_zero = 0; m_ovf = 0;
    end else if (!stall) begin
      a   = pick(f_rs, rs_val, m_result, wb_data);
      rtf = pick(f_rt, rt_val, m_result, wb_data);
      model_alu(alu_op, a, alu_src ? imm : rtf, r, v);
      m_result = r; m_store = rtf; m_wn = id_wn; m_WB = id_WB; m_M = id_M;
      m_zero = (r == 0); m_ovf = v;
    end
  end

  // compare process: every cycle, shortly after the active edge
  always @(posedge clk) begin
    #2;
    chk("cyc_result", ex_result, m_result);
    chk("cyc_store",  ex_store,  m_store);
    chk("cyc_wn",     {27'h0, ex_wn}, {27'h0, m_wn});
    chk("cyc_ctl",    {28'h0, ex_WB, ex_M}, {28'h0, m_WB, m_M});
    chk("cyc_flags",  {30'h0, ex_zero, ex_ovf}, {30'h0, m_zero, m_ovf});
  end

  task automatic apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] im, input logic src, input logic [1:0] frs,
                       input logic [1:0] frt, input logic [31:0] wb, input logic [4:0] wn,
                       input logic [1:0] wbc, input logic [1:0] mc,
                       input logic st, input logic fl);
    alu_op = op; rs_val = rs; rt_val = rt; imm = im; alu_src = src;
    f_rs = frs; f_rt = frt; wb_data = wb; id_wn = wn; id_WB = wbc; id_M = mc;
    stall = st; flush = fl;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, ex_result | ex_store | {27'h0, ex_wn} | {28'h0, ex_WB, ex_M}
              | {30'h0, ex_zero, ex_ovf}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    stall = 0; flush = 0; rs_val = 0; rt_val = 0; imm = 0; alu_src = 0;
    alu_op = 0; f_rs = 0; f_rt = 0; wb_data = 0; id_wn = 0; id_WB = 0; id_M = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b1;

    // ADD overflow
    apply(4'd0, 32'h7FFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0, 5'd3, 2'b01, 2'b00, 0, 0);
    chk("add_ovf_result", ex_result, 32'h80000000);
    chk("add_ovf_flags", {30'h0, ex_zero, ex_ovf}, 32'h1);
    chk("add_ovf_wn", {27'h0, ex_wn}, 32'd3);

    // EX/MEM forward
    apply(4'd0, 32'd5, 32'd3, 0, 0, 2'b00, 2'b00, 0, 5'd4, 2'b00, 2'b00, 0, 0);
    chk("fwd1_add", ex_result, 32'd8);
    apply(4'd1, 32'd99, 32'd8, 0, 0, 2'b01, 2'b00, 0, 5'd5, 2'b00, 2'b00, 0, 0);
    chk("fwd1_sub", ex_result, 32'd0);
    chk("fwd1_zero", {31'h0, ex_zero}, 32'd1);

    // MEM/WB forward on rt
    apply(4'd4, 32'hFFFFFFFF, 32'h12345678, 0, 0, 2'b00, 2'b10, 32'hA5A5A5A5,
          5'd6, 2'b11, 2'b10, 0, 0);
    chk("fwd2_xor", ex_result, 32'h5A5A5A5A);
    chk("fwd2_store", ex_store, 32'hA5A5A5A5);

    // select 11 behaves like register file; forward into rt from EX/MEM
    apply(4'd2, 32'hF0F0FFFF, 32'h0, 0, 0, 2'b11, 2'b01, 32'h1, 5'd7, 2'b00, 2'b00, 0, 0);
    chk("fwd11_and", ex_result, 32'h50505A5A);

    // other ops
    apply(4'd3, 32'h0F00, 32'h00F0, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("or", ex_result, 32'h0FF0);
    apply(4'd5, 32'h0F00, 32'h00F0, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("nor", ex_result, 32'hFFFFF00F);
    apply(4'd1, 32'h80000000, 32'd1, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("sub_ovf", {ex_result[31:1], ex_ovf}, {31'h3FFFFFFF, 1'b1});
    apply(4'd0, 32'hFFFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("add_wrap", {ex_result[30:0], ex_zero}, 32'h1);
    chk("add_wrap_noovf", {31'h0, ex_ovf}, 32'h0);
    apply(4'd7, 32'h1, 32'h0, 32'd31, 1, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("sll31", ex_result, 32'h80000000);
    apply(4'd8, 32'h80000000, 32'h0, 32'd4, 1, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("srl4", ex_result, 32'h08000000);
    apply(4'd9, 32'h80000000, 32'h0, 32'd4, 1, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("sra4", ex_result, 32'hF8000000);
    apply(4'd6, 32'hFFFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("slt", ex_result, 32'd1);
    apply(4'd6, 32'd1, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("slt_rev", ex_result, 32'd0);
    apply(4'hA, 32'h0, 32'h0, 32'hFFFF1234, 1, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("lui", ex_result, 32'h12340000);
    apply(4'hF, 32'h1234, 32'h5678, 0, 0, 2'b00, 2'b00, 0, 5'd1, 2'b00, 2'b00, 0, 0);
    chk("op_f", ex_result, 32'h0);
    chk("op_f_zero", {31'h0, ex_zero}, 32'd1);

    // stall then flush
    apply(4'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 5'd9, 2'b10, 2'b01, 0, 0);
    chk("st_load", ex_result, 32'd2);
    apply(4'd0, 32'd40, 32'd2, 0, 0, 2'b00, 2'b00, 0, 5'd10, 2'b01, 2'b10, 1, 0);
    chk("st_hold", ex_result, 32'd2);
    chk("st_hold_wn", {27'h0, ex_wn}, 32'd9);
    apply(4'd0, 32'd40, 32'd2, 0, 0, 2'b00, 2'b00, 0, 5'd10, 2'b01, 2'b10, 1, 1);
    chk_all_zero("st_flush");

    // async reset mid-cycle, during a stall
    apply(4'd0, 32'd7, 32'd0, 0, 0, 2'b00, 2'b00, 0, 5'd2, 2'b10, 2'b00, 0, 0);
    chk("pre_rst_wb", {30'h0, ex_WB}, 32'd2);
    stall = 1'b1;
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    apply(4'd0, 32'd20, 32'd22, 0, 0, 2'b00, 2'b00, 0, 5'd8, 2'b11, 2'b11, 0, 0);
    chk("post_rst_load", ex_result, 32'd42);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
